// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants one execution-unit result per cycle into a
// single registered broadcast slot feeding the ROB and reservation stations.
// Optional feature macro: CDB_ARBITER_ROUND_ROBIN_EN
//   defined   -> round-robin arbitration with a rotating priority pointer
//   undefined -> fixed priority, lowest port index wins, no pointer register

package global_variables;
  localparam int unsigned XLEN = 32;
endpackage

module cdb_arbiter #(
  parameter int unsigned PORTS = 4,
  parameter int unsigned XLEN  = global_variables::XLEN
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic [PORTS-1:0]           req_valid,
  output logic [PORTS-1:0]           req_ready,
  input  logic [PORTS-1:0][XLEN-1:0] req_result,
  input  logic [PORTS-1:0][XLEN-1:0] req_address,
  input  logic [PORTS-1:0][XLEN-1:0] req_jmp_address,
  input  logic [PORTS-1:0][5:0]      req_arn,
  input  logic [PORTS-1:0][5:0]      req_rrn,
  input  logic [PORTS-1:0]           req_reg_write,
  input  logic                       cdb_ready,
  output logic [XLEN-1:0]            cdb_result,
  output logic [XLEN-1:0]            cdb_address,
  output logic [XLEN-1:0]            cdb_jmp_address,
  output logic [5:0]                 cdb_arn,
  output logic [5:0]                 cdb_rrn,
  output logic [7:0]                 cdb_select,
  output logic                       cdb_reg_write,
  output logic                       cdb_valid
);

  localparam int unsigned IDXW = (PORTS > 1) ? $clog2(PORTS) : 1;

  // Broadcast register
  logic [XLEN-1:0] r_result;
  logic [XLEN-1:0] r_address;
  logic [XLEN-1:0] r_jmp_address;
  logic [5:0]      r_arn;
  logic [5:0]      r_rrn;
  logic [7:0]      r_select;
  logic            r_reg_write;
  logic            r_valid;

  // Next broadcast contents
  logic [XLEN-1:0] w_nxt_result;
  logic [XLEN-1:0] w_nxt_address;
  logic [XLEN-1:0] w_nxt_jmp_address;
  logic [5:0]      w_nxt_arn;
  logic [5:0]      w_nxt_rrn;
  logic [7:0]      w_nxt_select;
  logic            w_nxt_reg_write;
  logic            w_nxt_valid;

  logic             w_loadable;
  logic             w_load_en;
  logic             w_any;
  logic             w_grant_en;
  logic [IDXW-1:0]  w_grant_idx;
  logic [IDXW-1:0]  w_base;
  logic [PORTS-1:0] w_grant;

  // Port examined at search position k when the search starts at base
  function automatic logic [IDXW-1:0] port_at(input logic [IDXW-1:0] base,
                                              input int unsigned     k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= PORTS) s = s - PORTS;
    return IDXW'(s);
  endfunction

`ifdef CDB_ARBITER_ROUND_ROBIN_EN
  logic [IDXW-1:0] r_ptr;

  // Rotate priority past the winner, only when a grant actually happens
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (w_grant_en) begin
      if (32'(w_grant_idx) == PORTS - 1) r_ptr <= '0;
      else                               r_ptr <= w_grant_idx + IDXW'(1);
    end
  end

  assign w_base = r_ptr;
`else
  assign w_base = '0;
`endif

  // Slot may accept a new value when empty or being drained this cycle
  assign w_loadable = ~r_valid | cdb_ready;
  assign w_load_en  = w_loadable | flush;

  // Find the first requesting port in priority order
  always_comb begin
    w_any       = 1'b0;
    w_grant_idx = '0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      if (!w_any && req_valid[port_at(w_base, k)]) begin
        w_any       = 1'b1;
        w_grant_idx = port_at(w_base, k);
      end
    end
  end

  assign w_grant_en = w_any & w_loadable & ~flush & reset_n;

  // One-hot grant back to the execution units (payload-independent)
  always_comb begin
    w_grant = '0;
    if (w_grant_en) w_grant[w_grant_idx] = 1'b1;
  end

  assign req_ready = w_grant;

  // Next broadcast: granted payload, otherwise an all-zero idle slot
  always_comb begin
    w_nxt_result      = '0;
    w_nxt_address     = '0;
    w_nxt_jmp_address = '0;
    w_nxt_arn         = '0;
    w_nxt_rrn         = '0;
    w_nxt_select      = '0;
    w_nxt_reg_write   = 1'b0;
    w_nxt_valid       = 1'b0;
    if (w_grant_en) begin
      w_nxt_result      = req_result[w_grant_idx];
      w_nxt_address     = req_address[w_grant_idx];
      w_nxt_jmp_address = req_jmp_address[w_grant_idx];
      w_nxt_arn         = req_arn[w_grant_idx];
      w_nxt_rrn         = req_rrn[w_grant_idx];
      w_nxt_select      = 8'(w_grant);
      w_nxt_reg_write   = req_reg_write[w_grant_idx];
      w_nxt_valid       = 1'b1;
    end
  end

  // Broadcast register: loads when drainable or flushed, holds when stalled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_result      <= '0;
      r_address     <= '0;
      r_jmp_address <= '0;
      r_arn         <= '0;
      r_rrn         <= '0;
      r_select      <= '0;
      r_reg_write   <= 1'b0;
      r_valid       <= 1'b0;
    end else if (w_load_en) begin
      r_result      <= w_nxt_result;
      r_address     <= w_nxt_address;
      r_jmp_address <= w_nxt_jmp_address;
      r_arn         <= w_nxt_arn;
      r_rrn         <= w_nxt_rrn;
      r_select      <= w_nxt_select;
      r_reg_write   <= w_nxt_reg_write;
      r_valid       <= w_nxt_valid;
    end
  end

  assign cdb_result      = r_result;
  assign cdb_address     = r_address;
  assign cdb_jmp_address = r_jmp_address;
  assign cdb_arn         = r_arn;
  assign cdb_rrn         = r_rrn;
  assign cdb_select      = r_select;
  assign cdb_reg_write   = r_reg_write;
  assign cdb_valid       = r_valid;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (PORTS=4, XLEN=32): vector table plus
// hand-written multi-cycle sequences for stall, flush and reset corners.
module tb_cdb_arbiter;

  localparam int P = 4;
  localparam int X = 32;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             flush;
  logic [P-1:0]     req_valid;
  logic [P-1:0]     req_ready;
  logic [P-1:0][X-1:0] req_result;
  logic [P-1:0][X-1:0] req_address;
  logic [P-1:0][X-1:0] req_jmp_address;
  logic [P-1:0][5:0]   req_arn;
  logic [P-1:0][5:0]   req_rrn;
  logic [P-1:0]     req_reg_write;
  logic             cdb_ready;
  logic [X-1:0]     cdb_result;
  logic [X-1:0]     cdb_address;
  logic [X-1:0]     cdb_jmp_address;
  logic [5:0]       cdb_arn;
  logic [5:0]       cdb_rrn;
  logic [7:0]       cdb_select;
  logic             cdb_reg_write;
  logic             cdb_valid;

  int n_checks = 0;
  int n_fail   = 0;

  cdb_arbiter #(.PORTS(P), .XLEN(X)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .flush           (flush),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_result      (req_result),
    .req_address     (req_address),
    .req_jmp_address (req_jmp_address),
    .req_arn         (req_arn),
    .req_rrn         (req_rrn),
    .req_reg_write   (req_reg_write),
    .cdb_ready       (cdb_ready),
    .cdb_result      (cdb_result),
    .cdb_address     (cdb_address),
    .cdb_jmp_address (cdb_jmp_address),
    .cdb_arn         (cdb_arn),
    .cdb_rrn         (cdb_rrn),
    .cdb_select      (cdb_select),
    .cdb_reg_write   (cdb_reg_write),
    .cdb_valid       (cdb_valid)
  );

  always #5 clk = ~clk;

  // Per-stamp, per-port payload pattern
  function automatic logic [31:0] f_res(input int s, input int p);
    return 32'hC0DE_0000 | 32'(s << 8) | 32'(p);
  endfunction
  function automatic logic [31:0] f_addr(input int s, input int p);
    return 32'h8000_0000 + 32'(s * 16 + p * 4);
  endfunction
  function automatic logic [31:0] f_jmp(input int s, input int p);
    return f_res(s, p) ^ 32'h5A5A_5A5A;
  endfunction
  function automatic logic [5:0] f_arn(input int s, input int p);
    return 6'((s * 3 + p) % 64);
  endfunction
  function automatic logic [5:0] f_rrn(input int s, input int p);
    return 6'((s * 5 + p * 7 + 1) % 64);
  endfunction
  function automatic logic f_rw(input int s, input int p);
    return 1'((s + p) % 2);
  endfunction

  task automatic set_payload(input int s);
    for (int p = 0; p < P; p++) begin
      req_result[p]      = f_res(s, p);
      req_address[p]     = f_addr(s, p);
      req_jmp_address[p] = f_jmp(s, p);
      req_arn[p]         = f_arn(s, p);
      req_rrn[p]         = f_rrn(s, p);
      req_reg_write[p]   = f_rw(s, p);
    end
  endtask

  // Expected broadcast register
  logic        e_valid, e_rw;
  logic [7:0]  e_sel;
  logic [31:0] e_res, e_addr, e_jmp;
  logic [5:0]  e_arn, e_rrn;

  task automatic exp_load(input int s, input int p);
    e_valid = 1'b1;
    e_sel   = 8'(1) << p;
    e_res   = f_res(s, p);
    e_addr  = f_addr(s, p);
    e_jmp   = f_jmp(s, p);
    e_arn   = f_arn(s, p);
    e_rrn   = f_rrn(s, p);
    e_rw    = f_rw(s, p);
  endtask

  task automatic exp_zero();
    e_valid = 1'b0; e_sel = '0; e_res = '0; e_addr = '0; e_jmp = '0;
    e_arn = '0; e_rrn = '0; e_rw = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_bus(input string tag);
    chk({tag, ".valid"},  32'(cdb_valid),       32'(e_valid));
    chk({tag, ".select"}, 32'(cdb_select),      32'(e_sel));
    chk({tag, ".result"}, cdb_result,           e_res);
    chk({tag, ".addr"},   cdb_address,          e_addr);
    chk({tag, ".jmp"},    cdb_jmp_address,      e_jmp);
    chk({tag, ".arn"},    32'(cdb_arn),         32'(e_arn));
    chk({tag, ".rrn"},    32'(cdb_rrn),         32'(e_rrn));
    chk({tag, ".rw"},     32'(cdb_reg_write),   32'(e_rw));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [3:0] valid;
    logic       rdy;
    logic       fl;
    logic [3:0] exp_ready;
    logic       exp_valid;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] v, input logic r, input logic f,
                              input logic [3:0] er, input logic ev);
    vec_t t;
    t.valid = v; t.rdy = r; t.fl = f; t.exp_ready = er; t.exp_valid = ev;
    return t;
  endfunction

  localparam int NV = 12;
  vec_t tbl [NV];

  initial begin
    int s;
    logic [3:0] exp_rdy;
    int exp_port;

    tbl[0]  = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0); // idle load clears slot
    tbl[1]  = mk(4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1);
    tbl[2]  = mk(4'b1000, 1'b0, 1'b0, 4'b0000, 1'b1); // stalled: hold
    tbl[3]  = mk(4'b1000, 1'b1, 1'b0, 4'b1000, 1'b1); // back-to-back replace
    tbl[4]  = mk(4'b0010, 1'b1, 1'b1, 4'b0000, 1'b0); // flush
    tbl[5]  = mk(4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1); // empty slot loads w/o ready
    tbl[6]  = mk(4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1);
    tbl[7]  = mk(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1); // stalled, nothing pending
    tbl[8]  = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0);
    tbl[9]  = mk(4'b0001, 1'b0, 1'b1, 4'b0000, 1'b0); // flush on empty slot
    tbl[10] = mk(4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1);
`ifdef CDB_ARBITER_ROUND_ROBIN_EN
    tbl[11] = mk(4'b0011, 1'b1, 1'b0, 4'b0010, 1'b1); // last winner 0 -> port 1
`else
    tbl[11] = mk(4'b0011, 1'b1, 1'b0, 4'b0001, 1'b1); // lowest index wins
`endif

    // Reset held with a request pending
    reset_n   = 1'b0;
    flush     = 1'b0;
    cdb_ready = 1'b1;
    req_valid = 4'b0100;
    set_payload(1);
    req_result[2] = 32'h0000_00AA;
    req_arn[2]    = 6'd5;
    req_rrn[2]    = 6'd37;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req_ready", 32'(req_ready), 32'h0);
    chk("rst.valid",     32'(cdb_valid), 32'h0);
    chk("rst.select",    32'(cdb_select), 32'h0);
    chk("rst.result",    cdb_result, 32'h0);

    // First grant after reset release, 1-cycle latency
    reset_n = 1'b1;
    #1;
    chk("first.req_ready", 32'(req_ready), 32'h4);
    tick();
    chk("first.valid",  32'(cdb_valid),  32'h1);
    chk("first.result", cdb_result,      32'hAA);
    chk("first.arn",    32'(cdb_arn),    32'd5);
    chk("first.rrn",    32'(cdb_rrn),    32'd37);
    chk("first.select", 32'(cdb_select), 32'h04);

    // Vector table
    for (int i = 0; i < NV; i++) begin
      s = 100 + i;
      set_payload(s);
      req_valid = tbl[i].valid;
      cdb_ready = tbl[i].rdy;
      flush     = tbl[i].fl;
      #1;
      chk($sformatf("tbl%0d.req_ready", i), 32'(req_ready), 32'(tbl[i].exp_ready));
      tick();
      if (tbl[i].exp_ready != 4'b0000) begin
        exp_port = 0;
        for (int p = 0; p < P; p++) if (tbl[i].exp_ready[p]) exp_port = p;
        exp_load(s, exp_port);
      end else if (!tbl[i].exp_valid) begin
        exp_zero();
      end
      check_bus($sformatf("tbl%0d", i));
    end
    flush = 1'b0;

    // Stall while port 1 broadcasts 0x1234 and port 3 waits
    req_valid     = 4'b0010;
    cdb_ready     = 1'b1;
    req_result[1] = 32'h0000_1234;
    #1;
    chk("stall.grant1", 32'(req_ready), 32'h2);
    tick();
    chk("stall.load1", cdb_result, 32'h1234);
    req_valid     = 4'b1000;
    req_result[3] = 32'h0000_3333;
    cdb_ready     = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d.req_ready", c), 32'(req_ready), 32'h0);
      tick();
      chk($sformatf("stall%0d.result", c), cdb_result, 32'h1234);
      chk($sformatf("stall%0d.select", c), 32'(cdb_select), 32'h02);
      chk($sformatf("stall%0d.valid", c),  32'(cdb_valid), 32'h1);
    end
    cdb_ready = 1'b1;
    #1;
    chk("stall.grant3", 32'(req_ready), 32'h8);
    tick();
    chk("stall.result3", cdb_result, 32'h3333);
    chk("stall.select3", 32'(cdb_select), 32'h08);

    // Flush of a stalled broadcast
    set_payload(200);
    req_valid = 4'b0001;
    #1;
    chk("flush.grant0", 32'(req_ready), 32'h1);
    tick();
    exp_load(200, 0);
    check_bus("flush.pre");
    req_valid = 4'b0000;
    cdb_ready = 1'b0;
    tick();
    check_bus("flush.held");
    req_valid = 4'b0001;
    flush     = 1'b1;
    #1;
    chk("flush.req_ready", 32'(req_ready), 32'h0);
    tick();
    exp_zero();
    check_bus("flush.post");
    flush = 1'b0;

    // Four ports contending after a fresh reset
    reset_n   = 1'b0;
    req_valid = 4'b0000;
    tick();
    reset_n   = 1'b1;
    req_valid = 4'b1111;
    cdb_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_payload(300 + k);
`ifdef CDB_ARBITER_ROUND_ROBIN_EN
      exp_port = k;
`else
      exp_port = 0;
`endif
      exp_rdy = 4'(1 << exp_port);
      #1;
      chk($sformatf("all%0d.req_ready", k), 32'(req_ready), 32'(exp_rdy));
      tick();
      chk($sformatf("all%0d.select", k), 32'(cdb_select), 32'(1 << exp_port));
      chk($sformatf("all%0d.result", k), cdb_result, f_res(300 + k, exp_port));
    end

    // Asynchronous reset in the middle of a valid broadcast
    req_valid = 4'b0000;
    cdb_ready = 1'b0;
    tick();
    chk("arst.pre_valid", 32'(cdb_valid), 32'h1);
    req_valid = 4'b0001;
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst.valid",     32'(cdb_valid),  32'h0);
    chk("arst.select",    32'(cdb_select), 32'h0);
    chk("arst.result",    cdb_result,      32'h0);
    chk("arst.req_ready", 32'(req_ready),  32'h0);
    tick();
    reset_n = 1'b1;
    set_payload(400);
    req_valid = 4'b1001;
    cdb_ready = 1'b1;
    #1;
    chk("arst.grant0", 32'(req_ready), 32'h1);
    tick();
    chk("arst.select0", 32'(cdb_select), 32'h01);
    chk("arst.result0", cdb_result, f_res(400, 0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter PORTS, default 4, giving the number of execution-unit requesters (2..8).
REQ-002 SHALL have parameter XLEN, default global_variables::XLEN, giving the data width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  mispredict flush; drops the in-flight broadcast.
REQ-006 SHALL have port req_valid  input  PORTS  per-unit result pending.
REQ-007 SHALL have port req_ready  output  PORTS  per-unit grant; the transfer occurs when valid&&ready.
REQ-008 SHALL have ports req_result, req_address, req_jmp_address  input  PORTSxXLEN  per-unit payload.
REQ-009 SHALL have ports req_arn, req_rrn  input  PORTSx6  per-unit architectural and rename register numbers.
REQ-010 SHALL have port req_reg_write  input  PORTS  per-unit flag marking a result destined for the register file.
REQ-011 SHALL have port cdb_ready  input  1  the downstream consumer (ROB) accepts the current broadcast.
REQ-012 SHALL have ports cdb_result, cdb_address, cdb_jmp_address  output  XLEN  broadcast payload.
REQ-013 SHALL have ports cdb_arn, cdb_rrn  output  6  broadcast register tags.
REQ-014 SHALL have port cdb_select  output  8  one-hot identifier of the granted port (bit i = port i); 0 when idle.
REQ-015 SHALL have port cdb_reg_write  output  1  copy of the granted req_reg_write, qualified by cdb_valid.
REQ-016 SHALL have port cdb_valid  output  1  broadcast register holds a valid result.

Function
REQ-017 SHALL drive all cdb_* outputs directly from a single output register (one broadcast per cycle).
REQ-018 SHALL treat the output register as loadable when cdb_valid==0 or cdb_ready==1.
REQ-019 SHALL assert at most one req_ready bit per cycle, and only for a port with req_valid==1 while the register is loadable and flush==0.
REQ-020 SHALL make req_ready combinational from req_valid, the priority state, cdb_valid, cdb_ready and flush, with no dependence on payload inputs.
REQ-021 SHALL load the granted payload, with cdb_select=1<<i and cdb_valid=1, on the edge following the grant, giving 1-cycle latency.
REQ-022 SHALL, when loadable with no request pending, load cdb_valid=0 and set every data field, cdb_select and cdb_reg_write to 0.
REQ-023 SHALL hold all cdb_* outputs stable while cdb_valid==1 and cdb_ready==0, with every req_ready deasserted.
REQ-024 SHALL, when cdb_ready==1 and a new grant occur in the same cycle, replace the broadcast back-to-back with no bubble.
REQ-025 SHALL, when flush==1, clear cdb_valid and zero all fields on the next edge regardless of cdb_ready, grant nothing that cycle, and leave the priority pointer unchanged.
REQ-026 SHALL never drop a presented result: a requester keeps req_valid and its payload until granted, which is the unit's obligation.

Reset
REQ-027 SHALL, while reset_n==0, immediately force cdb_valid=0, zero all cdb_* fields and set the priority pointer to 0 (port 0 highest priority).
REQ-028 SHALL, on reset assertion mid-broadcast, discard the held result; req_ready is 0 while reset_n==0.

Configuration
REQ-029 SHALL use the macro CDB_ARBITER_ROUND_ROBIN_EN to select the arbitration policy.
REQ-030 SHALL, with the macro defined, use round-robin: search starts at (last granted index+1) mod PORTS, and the pointer updates only on an actual grant.
REQ-031 SHALL, with the macro undefined, use fixed priority (lowest index wins) and contain no pointer register.

Verification
REQ-032 SHALL cover: reset released with port 2 presenting result 0x0000_00AA, arn 5, rrn 37 -> req_ready=0b0100 in the same cycle; next cycle cdb_valid=1, cdb_result=0xAA, cdb_arn=5, cdb_rrn=37, cdb_select=0x04.
REQ-033 SHALL cover: all 4 ports valid for 4 cycles with cdb_ready=1 (round robin) -> grants in order 0,1,2,3 on consecutive cycles; with the macro undefined -> port 0 granted every cycle.
REQ-034 SHALL cover: cdb_ready=0 for 3 cycles while port 1 is broadcasting 0x1234 and port 3 is waiting -> outputs hold 0x1234 and req_ready=0; grant goes to port 3 in the cycle cdb_ready rises, with port 3's value on the bus the next cycle.
REQ-035 SHALL cover: flush asserted while a broadcast is held stalled -> next cycle cdb_valid=0, cdb_select=0, all fields 0, and no req_ready during the flush cycle.
REQ-036 SHALL cover: reset_n dropped asynchronously mid-cycle during a valid broadcast -> cdb_valid falls before the next clk edge; after release, port 0 wins a simultaneous port 0/port 3 request.
